minterm_sweep_checker: RTL and testbench
========================================

# minterm_sweep_checker

Sequential stimulus and check stage for the 4-input sum-of-minterms logic block F(W,X,Y,Z) = m(0,1,8,9,10,11,12,14,15). It feeds the function's inputs and consumes its output. On a start request it drives all 16 input vectors in ascending order. It waits a programmable settle time on each vector, then samples the function output and compares it against the expected minterm mask. At the end it reports a pass/fail verdict, the mismatch count, and the first failing vector. It replaces hand-inspected monitor logs with a hardware self-check that can sit beside the function block in synthesis or simulation.

## Interface
Parameters:
- MINTERMS, 16'hDF03, expected truth table; bit i is the required output for vector i (W = MSB).
- SETTLE, 2, settle cycles per vector before sampling; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  level-sampled sweep request; acted on only in IDLE or DONE.
- f_in  in  1  output of the function under test.
- vec_out  out  4  current input vector {W,X,Y,Z} driven to the function.
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- pass  out  1  high when the last completed sweep had zero mismatches.
- err_count  out  5  number of mismatching vectors (0..16).
- first_err_vec  out  4  vector of the first mismatch.
- err_valid  out  1  high when first_err_vec holds a captured value.

## Operation
- States:
  - IDLE: default state. start=1 → LOAD.
  - LOAD: vec_out←0, settle counter←SETTLE-1, err_count←0, err_valid←0, pass←0, busy←1 → WAIT.
  - WAIT: counter decrements each cycle; at 0 → SAMPLE.
  - SAMPLE: compares f_in with MINTERMS[vec_out].
    - On mismatch: err_count+1. If err_valid=0, first_err_vec←vec_out and err_valid←1.
    - If vec_out=15 → DONE.
    - Otherwise vec_out+1, counter←SETTLE-1 → WAIT.
  - DONE: busy←0, done=1 for exactly the entry cycle, pass←(err_count==0). Results hold. start=1 → LOAD, which clears the results.
- vec_out changes only on the LOAD→WAIT and SAMPLE→WAIT transitions and is held stable during WAIT and SAMPLE.
- Vector wrap: vec_out never wraps to 0 inside a sweep. After sampling vector 15, vec_out stays at 15 in DONE.
- start while busy is ignored, with no restart and no queuing.
- err_count is 5 bits, so the 16-mismatch case is representable without saturation logic.
- The comparison uses the f_in value present at the rising edge that ends the SAMPLE cycle. f_in is not re-registered.

## Timing
- Reset values: vec_out=0, busy=0, done=0, pass=0, err_count=0, first_err_vec=0, err_valid=0, state=IDLE.
- Reset mid-sweep aborts immediately to the reset values; no done pulse is produced.
- Cycle 0 is the edge that samples start=1 in IDLE. LOAD occupies cycle 1. busy=1 and vec_out=0 are visible from cycle 2.
- Each vector occupies SETTLE WAIT cycles plus 1 SAMPLE cycle.
- done is high in cycle 2+16·(SETTLE+1); with the default SETTLE=2 that is cycle 50.
- err_count and first_err_vec update on the edge ending the SAMPLE cycle. pass updates on DONE entry, in the same cycle as done.
- start=1 held continuously in DONE restarts the sweep one cycle after DONE. The DONE cycle is still observed, with done=1.

## Test plan
- Correct function model on f_in, start pulsed once → done at cycle 50, pass=1, err_count=0, err_valid=0; vec_out visits 0..15 in order, each held 3 cycles.
- Inverted function (~F) → err_count=16, first_err_vec=0, err_valid=1, pass=0.
- f_in stuck at 0 → err_count=9, first_err_vec=0; stuck at 1 → err_count=7, first_err_vec=2.
- Single fault, F forced wrong only at vector 10 → err_count=1, first_err_vec=10, pass=0; a back-to-back second start with the fault removed clears the results, then pass=1.
- start toggled during busy at vectors 3 and 9 → no restart; done still at cycle 50; exactly one done pulse.
- rst_n pulsed low at vector 7 (mid-WAIT) → all outputs return to reset values asynchronously, before the next clock edge; no done pulse; a new start performs a full clean sweep.

Source files
------------

// File: rtl/minterm_sweep_checker.sv
// minterm_sweep_checker
//
// Sweeps the 16 input vectors of a 4-input function block in ascending
// order. After each vector has settled it checks the block's output against
// the expected truth table, and at the end it reports a verdict.
//
// Parameters
//   MINTERMS  expected truth table; bit i is the required output for vector i
//   SETTLE    settle cycles per vector before sampling (1..15)
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          level-sampled sweep request, honoured in IDLE/DONE only
//   f_in           output of the function under test
//   vec_out        current input vector {W,X,Y,Z}
//   busy           high while a sweep is in progress
//   done           one-cycle pulse on sweep completion
//   pass           last completed sweep had zero mismatches
//   err_count      number of mismatching vectors (0..16)
//   first_err_vec  vector of the first mismatch
//   err_valid      first_err_vec holds a captured value
//   state_dbg      current FSM state (IDLE=0 LOAD=1 WAIT=2 SAMPLE=3 DONE=4)
//
// Handshake: start is a plain level request. A sweep begins when start is
// high on a rising edge while the FSM is in IDLE or DONE. Requests at any
// other time are dropped; they are neither queued nor do they restart the sweep.
module minterm_sweep_checker #(
    parameter logic [15:0] MINTERMS = 16'hDF03,
    parameter int          SETTLE   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       f_in,
    output logic [3:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_err_vec,
    output logic       err_valid,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WAIT   = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] settle_cnt;
    logic       mismatch;
    logic [4:0] err_next;

    // f_in is compared directly at the edge that ends SAMPLE, with no extra register.
    always_comb begin
        mismatch = 1'b0;
        err_next = err_count;
        mismatch = (f_in != MINTERMS[vec_out]);
        err_next = err_count + 5'(mismatch);
    end

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            settle_cnt    <= 4'd0;
            vec_out       <= 4'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_count     <= 5'd0;
            first_err_vec <= 4'd0;
            err_valid     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) state <= S_LOAD;
                end
                S_LOAD: begin
                    vec_out       <= 4'd0;
                    settle_cnt    <= SETTLE_INIT;
                    err_count     <= 5'd0;
                    first_err_vec <= 4'd0;
                    err_valid     <= 1'b0;
                    pass          <= 1'b0;
                    busy          <= 1'b1;
                    state         <= S_WAIT;
                end
                S_WAIT: begin
                    // The counter starts at SETTLE-1 and exits on zero,
                    // so WAIT lasts exactly SETTLE cycles.
                    if (settle_cnt == 4'd0) state <= S_SAMPLE;
                    else                    settle_cnt <= settle_cnt - 4'd1;
                end
                S_SAMPLE: begin
                    err_count <= err_next;
                    if (mismatch && !err_valid) begin
                        first_err_vec <= vec_out;
                        err_valid     <= 1'b1;
                    end
                    if (vec_out == 4'd15) begin
                        // Vector 15 is the last one and vec_out stays at 15.
                        // pass uses the updated count, so it includes this final sample.
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 5'd0);
                        state <= S_DONE;
                    end else begin
                        vec_out    <= vec_out + 4'd1;
                        settle_cnt <= SETTLE_INIT;
                        state      <= S_WAIT;
                    end
                end
                S_DONE: begin
                    if (start) state <= S_LOAD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench for minterm_sweep_checker with the default parameters.
// The bench models the function block from vec_out. In its own time base,
// cycle 0 is the edge that samples start, and cycle n is the period that
// follows edge n-1.
module tb_minterm_sweep_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       f_in;
    logic [3:0] vec_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_count;
    logic [3:0] first_err_vec;
    logic       err_valid;
    logic [2:0] state_dbg;

    int checks;
    int failures;

    // Function model: 0 correct, 1 inverted, 2 stuck 0, 3 stuck 1, 4 wrong at vector 10.
    int          mode;
    logic [15:0] golden;

    minterm_sweep_checker dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .f_in          (f_in),
        .vec_out       (vec_out),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_vec (first_err_vec),
        .err_valid     (err_valid),
        .state_dbg     (state_dbg)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        f_in = 1'b0;
        case (mode)
            0: f_in = golden[vec_out];
            1: f_in = ~golden[vec_out];
            2: f_in = 1'b0;
            3: f_in = 1'b1;
            4: f_in = (vec_out == 4'd10) ? ~golden[vec_out] : golden[vec_out];
            default: f_in = golden[vec_out];
        endcase
    end

    // Starts a sweep and returns at #1 after the edge where done is first
    // seen. start is pulsed during cycles tog_a and tog_b. The task also
    // counts the cycles in 2..49 whose vec_out/busy disagree with the
    // expected schedule (vector (c-2)/3, busy high).
    task automatic run_sweep(input int tog_a, input int tog_b,
                             output int done_cyc, output int vec_bad);
        int cyc;
        done_cyc = -1;
        vec_bad  = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        while (cyc < 100 && done_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            start = (cyc == tog_a || cyc == tog_b);
            if (cyc >= 2 && cyc <= 49) begin
                if (vec_out !== 4'((cyc - 2) / 3) || busy !== 1'b1) vec_bad++;
            end
            if (done === 1'b1) done_cyc = cyc;
        end
        start = 1'b0;
    endtask

    task automatic check_result(input string name, input int done_cyc,
                                input logic exp_pass, input logic [4:0] exp_cnt,
                                input logic exp_valid, input logic [3:0] exp_vec);
        checks++;
        if (done_cyc !== 50) begin
            failures++;
            $display("FAIL %s done_cycle: got %0d expected 50", name, done_cyc);
        end
        checks++;
        if (pass !== exp_pass) begin
            failures++;
            $display("FAIL %s pass: got %b expected %b", name, pass, exp_pass);
        end
        checks++;
        if (err_count !== exp_cnt) begin
            failures++;
            $display("FAIL %s err_count: got %0d expected %0d", name, err_count, exp_cnt);
        end
        checks++;
        if (err_valid !== exp_valid) begin
            failures++;
            $display("FAIL %s err_valid: got %b expected %b", name, err_valid, exp_valid);
        end
        checks++;
        if (first_err_vec !== exp_vec) begin
            failures++;
            $display("FAIL %s first_err_vec: got %0d expected %0d", name, first_err_vec, exp_vec);
        end
        checks++;
        if (busy !== 1'b0 || vec_out !== 4'd15) begin
            failures++;
            $display("FAIL %s done_state: got busy=%b vec=%0d expected busy=0 vec=15", name, busy, vec_out);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if (vec_out !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_count !== 5'd0 || first_err_vec !== 4'd0 || err_valid !== 1'b0 ||
            state_dbg !== 3'd0) begin
            failures++;
            $display("FAIL %s: got vec=%0d busy=%b done=%b pass=%b cnt=%0d fev=%0d ev=%b st=%0d expected all zero",
                     name, vec_out, busy, done, pass, err_count, first_err_vec, err_valid, state_dbg);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #12;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_correct();
        int dc, vb;
        mode = 0;
        run_sweep(-1, -1, dc, vb);
        check_result("correct", dc, 1'b1, 5'd0, 1'b0, 4'd0);
        checks++;
        if (vb !== 0) begin
            failures++;
            $display("FAIL correct vec_schedule: got %0d bad cycles expected 0", vb);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || pass !== 1'b1 || vec_out !== 4'd15) begin
            failures++;
            $display("FAIL correct done_pulse: got done=%b pass=%b vec=%0d expected 0 1 15", done, pass, vec_out);
        end
        @(negedge clk);
    endtask

    task automatic test_inverted();
        int dc, vb;
        mode = 1;
        run_sweep(-1, -1, dc, vb);
        check_result("inverted", dc, 1'b0, 5'd16, 1'b1, 4'd0);
        @(negedge clk);
    endtask

    task automatic test_stuck();
        int dc, vb;
        mode = 2;
        run_sweep(-1, -1, dc, vb);
        check_result("stuck0", dc, 1'b0, 5'd9, 1'b1, 4'd0);
        @(negedge clk);
        mode = 3;
        run_sweep(-1, -1, dc, vb);
        check_result("stuck1", dc, 1'b0, 5'd7, 1'b1, 4'd2);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int dc, vb;
        mode = 4;
        run_sweep(-1, -1, dc, vb);
        check_result("single_fault", dc, 1'b0, 5'd1, 1'b1, 4'd10);
        // Still inside the DONE cycle: start is already high for the next edge.
        mode = 0;
        run_sweep(-1, -1, dc, vb);
        check_result("back_to_back", dc, 1'b1, 5'd0, 1'b0, 4'd0);
        checks++;
        if (vb !== 0) begin
            failures++;
            $display("FAIL back_to_back vec_schedule: got %0d bad cycles expected 0", vb);
        end
        @(negedge clk);
    endtask

    task automatic test_busy_start();
        int dc, vb, extra;
        mode = 0;
        // Cycle 11 is in vector 3 and cycle 29 is in vector 9.
        run_sweep(11, 29, dc, vb);
        check_result("busy_start", dc, 1'b1, 5'd0, 1'b0, 4'd0);
        checks++;
        if (vb !== 0) begin
            failures++;
            $display("FAIL busy_start vec_schedule: got %0d bad cycles expected 0", vb);
        end
        extra = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || state_dbg !== 3'd4) begin
            failures++;
            $display("FAIL busy_start extra_done: got %0d pulses state=%0d expected 0 pulses state=4", extra, state_dbg);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dc, vb, pulses;
        mode = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // Cycle 23 is the first WAIT cycle of vector 7.
        repeat (22) @(posedge clk);
        #1;
        checks++;
        if (vec_out !== 4'd7 || busy !== 1'b1 || state_dbg !== 3'd2) begin
            failures++;
            $display("FAIL reset_mid pre: got vec=%0d busy=%b st=%0d expected 7 1 2", vec_out, busy, state_dbg);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("reset_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid no_done: got %0d active cycles expected 0", pulses);
        end
        @(negedge clk);
        run_sweep(-1, -1, dc, vb);
        check_result("after_reset", dc, 1'b1, 5'd0, 1'b0, 4'd0);
        checks++;
        if (vb !== 0) begin
            failures++;
            $display("FAIL after_reset vec_schedule: got %0d bad cycles expected 0", vb);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        golden   = 16'hDF03;
        mode     = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        test_reset();
        test_correct();
        test_inverted();
        test_stuck();
        test_back_to_back();
        test_busy_start();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
